// File: rtl/layer_sequencer.sv
// layer_sequencer: starts the layer engines one after another, grants the shared
// feature-map RAM to the running layer and reports run status to the PS.
module layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 1048576
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          go,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          err_timeout,
    output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
    output logic [31:0]                   perf_cycles,
    output logic [NUM_LAYERS-1:0]         layer_start,
    input  logic [NUM_LAYERS-1:0]         layer_end,
    input  logic [NUM_LAYERS*ADDR_W-1:0]  l_ram_addr_w,
    input  logic [NUM_LAYERS*DATA_W-1:0]  l_ram_data_w,
    input  logic [NUM_LAYERS-1:0]         l_ram_en,
    input  logic [NUM_LAYERS-1:0]         l_ram_wea,
    input  logic [NUM_LAYERS-1:0]         l_ram_en_r,
    input  logic [NUM_LAYERS*ADDR_W-1:0]  l_ram_addr_r,
    output logic [ADDR_W-1:0]             ram_addr_w,
    output logic [DATA_W-1:0]             ram_data_w,
    output logic                          ram_en,
    output logic                          ram_wea,
    output logic [ADDR_W-1:0]             ram_addr_r,
    output logic                          ram_en_r
);
    localparam int IDX_W = $clog2(NUM_LAYERS);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, RUN, GAP, FIN, ERR} state_t;

    state_t                state, state_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [WD_W-1:0]       wdog, wdog_next;
    logic [NUM_LAYERS-1:0] end_q;
    logic                  err_next;
    logic                  done_next;
    logic                  perf_clear;
    logic                  end_cur;
    logic                  end_prev;
    logic                  end_edge;
    logic                  granted;

    // Only the granted layer's end bit is ever looked at; other layers' ends are don't-care.
    always_comb begin
        end_cur  = 1'b0;
        end_prev = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (idx == IDX_W'(k)) begin
                end_cur  = layer_end[k];
                end_prev = end_q[k];
            end
        end
    end

    assign end_edge  = end_cur && !end_prev;
    assign granted   = (state == START) || (state == RUN) || (state == GAP) || (state == FIN);
    assign busy      = granted;
    assign cur_layer = idx;

    always_comb begin
        layer_start = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if ((state == START) && (idx == IDX_W'(k))) begin
                layer_start[k] = 1'b1;
            end
        end
    end

    // Shared RAM port is a pure mux on idx so the active layer sees no extra latency.
    always_comb begin
        ram_addr_w = '0;
        ram_data_w = '0;
        ram_en     = 1'b0;
        ram_wea    = 1'b0;
        ram_addr_r = '0;
        ram_en_r   = 1'b0;
        if (granted) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (idx == IDX_W'(k)) begin
                    ram_addr_w = l_ram_addr_w[k*ADDR_W +: ADDR_W];
                    ram_data_w = l_ram_data_w[k*DATA_W +: DATA_W];
                    ram_en     = l_ram_en[k];
                    ram_wea    = l_ram_wea[k];
                    ram_addr_r = l_ram_addr_r[k*ADDR_W +: ADDR_W];
                    ram_en_r   = l_ram_en_r[k];
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        wdog_next  = wdog;
        err_next   = err_timeout;
        done_next  = 1'b0;
        perf_clear = 1'b0;
        case (state)
            IDLE: begin
                if (go && !abort) begin
                    state_next = START;
                    idx_next   = '0;
                    err_next   = 1'b0;
                    perf_clear = 1'b1;
                end
            end
            START: begin
                wdog_next  = '0;
                state_next = RUN;
            end
            RUN: begin
                wdog_next = wdog + WD_W'(1);
                if (end_edge) begin
                    state_next = (idx == LAST_IDX) ? FIN : GAP;
                end else if (wdog == WD_LIMIT) begin
                    state_next = ERR;
                    err_next   = 1'b1;
                end
            end
            GAP: begin
                if (!end_cur) begin
                    idx_next   = idx + IDX_W'(1);
                    state_next = START;
                end
            end
            FIN: begin
                if (!end_cur) begin
                    done_next  = 1'b1;
                    idx_next   = '0;
                    state_next = IDLE;
                end
            end
            ERR: begin
                if (go && !abort) begin
                    state_next = START;
                    idx_next   = '0;
                    err_next   = 1'b0;
                    perf_clear = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
        // Abort beats everything, including a same-cycle end edge or timeout; the error flag is left untouched.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            idx_next   = '0;
            done_next  = 1'b0;
            err_next   = err_timeout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            wdog        <= wdog_next;
            err_timeout <= err_next;
            done        <= done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_q <= '0;
        end else begin
            end_q <= layer_end;
        end
    end

    // Run cycle counter holds after the run ends so the PS can read it at leisure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (perf_clear) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: layer-engine models around layer_sequencer, checked every
// cycle against a run schedule computed arithmetically from the handshake rules.
`timescale 1ns/1ps
module tb_layer_sequencer;
    localparam int NL = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 64;

    typedef struct packed {
        logic [NL-1:0][7:0] d;
        logic [NL-1:0][7:0] h;
        int                 stall;
        logic               pat;
        logic               spur;
        logic               go_busy;
        int                 exp_perf;
        logic               exp_err;
    } run_rec_t;

    logic             clk;
    logic             rst_n;
    logic             go;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic [1:0]       cur_layer;
    logic [31:0]      perf_cycles;
    logic [NL-1:0]    layer_start;
    logic [NL-1:0]    layer_end;
    logic [NL*AW-1:0] l_ram_addr_w;
    logic [NL*DW-1:0] l_ram_data_w;
    logic [NL-1:0]    l_ram_en;
    logic [NL-1:0]    l_ram_wea;
    logic [NL-1:0]    l_ram_en_r;
    logic [NL*AW-1:0] l_ram_addr_r;
    logic [AW-1:0]    ram_addr_w;
    logic [DW-1:0]    ram_data_w;
    logic             ram_en;
    logic             ram_wea;
    logic [AW-1:0]    ram_addr_r;
    logic             ram_en_r;

    logic [AW-1:0] la_w [NL];
    logic [DW-1:0] ld_w [NL];
    logic [AW-1:0] la_r [NL];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int            cfg_d [NL];
    int            cfg_h [NL];
    int            cfg_stall;
    bit            mdl_active [NL];
    int            mdl_age [NL];
    logic [NL-1:0] mdl_end;
    bit            spur_on;
    int            spur_s1;
    bit            pat_on;

    int s_cyc [NL];
    int end_cyc;
    bit exp_err_run;

    run_rec_t tbl [6];

    layer_sequencer #(
        .NUM_LAYERS(NL), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .cur_layer(cur_layer), .perf_cycles(perf_cycles),
        .layer_start(layer_start), .layer_end(layer_end),
        .l_ram_addr_w(l_ram_addr_w), .l_ram_data_w(l_ram_data_w),
        .l_ram_en(l_ram_en), .l_ram_wea(l_ram_wea), .l_ram_en_r(l_ram_en_r),
        .l_ram_addr_r(l_ram_addr_r),
        .ram_addr_w(ram_addr_w), .ram_data_w(ram_data_w), .ram_en(ram_en),
        .ram_wea(ram_wea), .ram_addr_r(ram_addr_r), .ram_en_r(ram_en_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "[TB] stopping on time limit");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: layer models react to the start pulses, then all layer inputs are driven.
    task automatic apply_stimulus();
        logic [NL-1:0] inj;
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < NL; k++) begin
            if (layer_start[k]) begin
                mdl_active[k] = 1'b1;
                mdl_age[k]    = 0;
            end else if (mdl_active[k]) begin
                mdl_age[k]++;
            end
            mdl_end[k] = mdl_active[k] && (cfg_stall != k) &&
                         (mdl_age[k] >= cfg_d[k]) && (mdl_age[k] < cfg_d[k] + cfg_h[k]);
            if (mdl_active[k] && (mdl_age[k] >= cfg_d[k] + cfg_h[k])) mdl_active[k] = 1'b0;
        end
        inj = '0;
        if (spur_on) begin
            inj[0] = (cyc >= spur_s1) && (cyc <= spur_s1 + 3);
            inj[3] = (cyc >= spur_s1 + 2) && (cyc <= spur_s1 + 4);
        end
        layer_end = mdl_end | inj;
        for (int k = 0; k < NL; k++) begin
            if (pat_on) begin
                la_w[k]      = (k == 2) ? 16'h8005 : 16'hFFFF;
                ld_w[k]      = (k == 2) ? 8'h7F : 8'hAA;
                la_r[k]      = (k == 2) ? 16'h0042 : 16'hFFFF;
                l_ram_en[k]  = 1'b1;
                l_ram_wea[k] = 1'b1;
                l_ram_en_r[k] = 1'b1;
            end else begin
                la_w[k]       = 16'($urandom);
                ld_w[k]       = 8'($urandom);
                la_r[k]       = 16'($urandom);
                l_ram_en[k]   = 1'($urandom);
                l_ram_wea[k]  = 1'($urandom);
                l_ram_en_r[k] = 1'($urandom);
            end
            l_ram_addr_w[k*AW +: AW] = la_w[k];
            l_ram_data_w[k*DW +: DW] = ld_w[k];
            l_ram_addr_r[k*AW +: AW] = la_r[k];
        end
        #1;
    endtask

    // Reference schedule: each layer occupies start + end delay + hold + 1 cycles.
    task automatic build_schedule(input int g);
        int t;
        t = g + 1;
        exp_err_run = 1'b0;
        for (int k = 0; k < NL; k++) s_cyc[k] = 32'h7FFF_FFFF;
        for (int k = 0; k < NL; k++) begin
            s_cyc[k] = t;
            if (cfg_stall == k) begin
                end_cyc     = t + TO + 1;
                exp_err_run = 1'b1;
                return;
            end
            t = t + cfg_d[k] + cfg_h[k] + 1;
        end
        end_cyc = t;
    endtask

    task automatic check_cycle(input int t);
        logic          exp_busy;
        logic          exp_done;
        logic          exp_err;
        logic [NL-1:0] exp_start;
        int            gk;
        int            pend;
        exp_busy  = (t >= s_cyc[0]) && (t < end_cyc);
        exp_done  = !exp_err_run && (t == end_cyc);
        exp_err   = exp_err_run && (t >= end_cyc);
        exp_start = '0;
        gk        = 0;
        for (int k = 0; k < NL; k++) begin
            if ((t == s_cyc[k]) && exp_busy) exp_start[k] = 1'b1;
            if (s_cyc[k] <= t) gk = k;
        end
        pend = (t < end_cyc) ? t : end_cyc;
        check_output("busy", busy, exp_busy);
        check_output("done", done, exp_done);
        check_output("err_timeout", err_timeout, exp_err);
        check_output("layer_start", layer_start, exp_start);
        check_output("perf_cycles", perf_cycles, pend - s_cyc[0]);
        if (exp_busy) begin
            check_output("cur_layer", cur_layer, gk);
            check_output("ram_addr_w", ram_addr_w, la_w[gk]);
            check_output("ram_data_w", ram_data_w, ld_w[gk]);
            check_output("ram_en", ram_en, l_ram_en[gk]);
            check_output("ram_wea", ram_wea, l_ram_wea[gk]);
            check_output("ram_addr_r", ram_addr_r, la_r[gk]);
            check_output("ram_en_r", ram_en_r, l_ram_en_r[gk]);
        end else begin
            if (!exp_err_run) check_output("cur_layer_idle", cur_layer, 0);
            check_output("ram_idle", {ram_addr_w, ram_data_w, ram_en, ram_wea, ram_addr_r, ram_en_r}, 0);
        end
    endtask

    task automatic run_cfg(input run_rec_t r, input bit use_exp);
        int busy_cnt;
        for (int k = 0; k < NL; k++) begin
            cfg_d[k] = int'(r.d[k]);
            cfg_h[k] = int'(r.h[k]);
        end
        cfg_stall = r.stall;
        go = 1'b1;
        build_schedule(cyc);
        spur_on  = r.spur;
        spur_s1  = s_cyc[1];
        pat_on   = r.pat;
        busy_cnt = 0;
        while (cyc < end_cyc + 2) begin
            apply_stimulus();
            go = r.go_busy && (cyc < end_cyc);
            check_cycle(cyc);
            if (busy) busy_cnt++;
        end
        go      = 1'b0;
        spur_on = 1'b0;
        pat_on  = 1'b0;
        check_output("perf_vs_busy", perf_cycles, busy_cnt);
        if (use_exp) begin
            check_output("perf_table", perf_cycles, r.exp_perf);
            check_output("err_table", err_timeout, r.exp_err);
        end
    endtask

    task automatic check_reset_state(input string name);
        check_output({name, "_busy"}, busy, 0);
        check_output({name, "_done"}, done, 0);
        check_output({name, "_err"}, err_timeout, 0);
        check_output({name, "_cur"}, cur_layer, 0);
        check_output({name, "_perf"}, perf_cycles, 0);
        check_output({name, "_start"}, layer_start, 0);
        check_output({name, "_ram"}, {ram_addr_w, ram_data_w, ram_en, ram_wea, ram_addr_r, ram_en_r}, 0);
    endtask

    function automatic run_rec_t mk_rec(input int d0, input int d1, input int d2, input int d3,
                                        input int h0, input int h1, input int h2, input int h3,
                                        input int stall, input bit pat, input bit spur,
                                        input bit gob, input int perf, input bit err);
        run_rec_t r;
        r.d[0] = 8'(d0); r.d[1] = 8'(d1); r.d[2] = 8'(d2); r.d[3] = 8'(d3);
        r.h[0] = 8'(h0); r.h[1] = 8'(h1); r.h[2] = 8'(h2); r.h[3] = 8'(h3);
        r.stall    = stall;
        r.pat      = pat;
        r.spur     = spur;
        r.go_busy  = gob;
        r.exp_perf = perf;
        r.exp_err  = err;
        return r;
    endfunction

    initial begin
        run_rec_t rr;
        rst_n = 1'b0;
        go    = 1'b0;
        abort = 1'b0;
        layer_end = '0;
        cfg_stall = -1;
        spur_on   = 1'b0;
        spur_s1   = 0;
        pat_on    = 1'b0;
        for (int k = 0; k < NL; k++) begin
            cfg_d[k] = 10; cfg_h[k] = 4; mdl_active[k] = 1'b0; mdl_age[k] = 0; s_cyc[k] = 0;
        end
        mdl_end = '0;
        end_cyc = 0;
        exp_err_run = 1'b0;

        tbl[0] = mk_rec(10, 10, 10, 10, 4, 4, 4, 4, -1, 1'b0, 1'b1, 1'b0, 60, 1'b0);
        tbl[1] = mk_rec( 1,  1,  1,  1, 1, 1, 1, 1, -1, 1'b0, 1'b0, 1'b0, 12, 1'b0);
        tbl[2] = mk_rec( 3,  7,  2,  5, 2, 1, 6, 3, -1, 1'b1, 1'b0, 1'b0, 33, 1'b0);
        tbl[3] = mk_rec(64,  1,  1,  1, 1, 1, 1, 1, -1, 1'b0, 1'b0, 1'b1, 75, 1'b0);
        tbl[4] = mk_rec(10, 10, 10, 10, 4, 4, 4, 4,  1, 1'b0, 1'b0, 1'b0, 80, 1'b1);
        tbl[5] = mk_rec(10, 10, 10, 10, 4, 4, 4, 4, -1, 1'b0, 1'b0, 1'b0, 60, 1'b0);

        repeat (3) apply_stimulus();
        check_reset_state("reset");
        rst_n = 1'b1;
        repeat (2) apply_stimulus();
        check_reset_state("idle");

        go = 1'b1;
        abort = 1'b1;
        apply_stimulus();
        go = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("go_abort_busy", busy, 0);
            check_output("go_abort_start", layer_start, 0);
        end

        for (int i = 0; i < 6; i++) run_cfg(tbl[i], 1'b1);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NL; k++) begin
                rr.d[k] = 8'($urandom_range(20, 1));
                rr.h[k] = 8'($urandom_range(6, 1));
            end
            rr.stall    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NL - 1, 0)) : -1;
            rr.pat      = 1'b0;
            rr.spur     = (rr.stall < 0) && 1'($urandom);
            rr.go_busy  = (rr.stall < 0) && 1'($urandom);
            rr.exp_perf = 0;
            rr.exp_err  = 1'b0;
            run_cfg(rr, 1'b0);
        end

        for (int k = 0; k < NL; k++) begin
            cfg_d[k] = 10; cfg_h[k] = 4;
        end
        cfg_stall = -1;
        go = 1'b1;
        build_schedule(cyc);
        apply_stimulus();
        go = 1'b0;
        check_cycle(cyc);
        while (cyc < s_cyc[2] + 3) begin
            apply_stimulus();
            check_cycle(cyc);
        end
        abort = 1'b1;
        apply_stimulus();
        abort = 1'b0;
        check_output("abort_busy", busy, 0);
        check_output("abort_cur", cur_layer, 0);
        check_output("abort_ram_en", ram_en, 0);
        for (int i = 0; i < 15; i++) begin
            check_output("abort_done", done, 0);
            check_output("abort_idle", busy, 0);
            apply_stimulus();
        end
        rst_n = 1'b0;
        for (int k = 0; k < NL; k++) mdl_active[k] = 1'b0;
        apply_stimulus();
        check_reset_state("rst_pulse");
        rst_n = 1'b1;
        apply_stimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
